uart_rx_frame_chk: RTL and testbench
====================================

UART_RX_FRAME_CHK -- requirements
Module: uart_rx_frame_chk

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning data bits per frame used for parity (legal 5..9).
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of each saturating error counter (legal 2..16).
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port sambled_bit  input  1  majority-sampled RX bit for the current bit slot.
REQ-006 SHALL have ports strt_chk_en, par_chk_en, stp_chk_en  input  1 each  one-cycle check strobes from the RX FSM.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  deserialised data, stable while par_chk_en is high.
REQ-008 SHALL have port par_typ  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port stp_two  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port cnt_clr  input  1  synchronous clear of all three counters.
REQ-011 SHALL have ports strt_glitch, par_err, stp_err  output  1 each  registered one-cycle check-fail flags.
REQ-012 SHALL have ports frame_done, frame_ok  output  1 each  one-cycle end-of-frame pulse; frame_ok = frame_done AND no error in that frame.
REQ-013 SHALL have ports glitch_cnt, par_err_cnt, stp_err_cnt  output  CNT_WIDTH each  saturating error counts.

Function
REQ-014 SHALL process at most one strobe per cycle, priority strt_chk_en > par_chk_en > stp_chk_en; lower-priority strobes in that cycle are ignored entirely.
REQ-015 SHALL, on a processed strt_chk_en, set strt_glitch next cycle to sambled_bit (1 = glitch), clear the frame error accumulator, and enter state STP1 regardless of current state.
REQ-016 SHALL, on a processed par_chk_en, set par_err next cycle to sambled_bit XOR (XOR-reduce data_in) XOR par_typ.
REQ-017 SHALL, on a processed stp_chk_en, set stp_err next cycle to NOT sambled_bit.
REQ-018 SHALL drive each of strt_glitch, par_err, stp_err low in every cycle where its own strobe was not processed (one-cycle flags, 1-cycle latency).
REQ-019 SHALL implement FSM states IDLE, STP1, STP2; reset state IDLE.
REQ-020 SHALL, in STP1 on stp_chk_en: latch stp_two; if stp_two = 0 end frame and go IDLE; if 1 go STP2.
REQ-021 SHALL, in STP2 on stp_chk_en, end frame and go IDLE; stp_two changes after STP1 are ignored for the current frame.
REQ-022 SHALL, on stp_chk_en in IDLE, still produce stp_err and count it but not produce frame_done.
REQ-023 SHALL, at frame end, pulse frame_done one cycle after the final stop strobe, with frame_ok = 1 only if no strt_glitch, par_err or stp_err occurred since the last strt_chk_en (including the final stop bit).
REQ-024 SHALL, on strt_chk_en while in STP2, abort the frame with no frame_done and restart in STP1.
REQ-025 SHALL increment each counter by 1 in the cycle its flag is set, saturating at 2^CNT_WIDTH-1 (no wrap).
REQ-026 SHALL give cnt_clr priority over a same-cycle increment: counter reads 0 next cycle.
REQ-027 SHALL keep par_chk_en functional in any state; parity errors outside a frame are counted but do not affect frame_ok.

Reset
REQ-028 SHALL, with RST high at a rising edge, force all flags, frame_done, frame_ok to 0, all counters to 0, FSM to IDLE, accumulator cleared; RST overrides all strobes and cnt_clr.
REQ-029 SHALL, if RST asserts mid-frame, produce no frame_done for that frame after release.

Verification
REQ-030 Clean frame, 8 bits, data 0xA5, even parity, start 0, parity 0, one stop 1 -> frame_done=1, frame_ok=1 one cycle after stop strobe; all counters 0.
REQ-031 Start strobe with sambled_bit=1 -> strt_glitch=1 for exactly one cycle, glitch_cnt=1; same frame otherwise clean -> frame_ok=0.
REQ-032 Odd parity, data 0x07, sampled parity 1 -> par_err=1, par_err_cnt=1; with sampled parity 0 -> par_err=0.
REQ-033 stp_two=1, stop bits 1 then 0 -> no frame_done after first stop; stp_err=1 and frame_done=1, frame_ok=0 after second.
REQ-034 CNT_WIDTH=2, five stop errors -> stp_err_cnt saturates at 3; cnt_clr together with sixth error -> stp_err_cnt=0.
REQ-035 strt_chk_en and stp_chk_en in same cycle, then RST mid-STP2 -> only start processed; after reset all outputs 0, state IDLE, no frame_done.

Source files
------------

// File: rtl/uart_rx_frame_chk.sv
// UART receive frame checker: start-glitch, parity and stop-bit checks driven by
// one-cycle strobes from the RX FSM, with end-of-frame status and saturating error counters.
module uart_rx_frame_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sambled_bit,
  input  logic                  strt_chk_en,
  input  logic                  par_chk_en,
  input  logic                  stp_chk_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  par_typ,
  input  logic                  stp_two,
  input  logic                  cnt_clr,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [CNT_WIDTH-1:0]  glitch_cnt,
  output logic [CNT_WIDTH-1:0]  par_err_cnt,
  output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STP1 = 2'd1,
    STP2 = 2'd2
  } state_t;

  state_t r_state;
  logic   r_frame_err;
  logic   r_strt_glitch;
  logic   r_par_err;
  logic   r_stp_err;
  logic   r_frame_done;
  logic   r_frame_ok;

  // One strobe per cycle: start wins over parity, parity wins over stop.
  logic w_do_strt;
  logic w_do_par;
  logic w_do_stp;
  assign w_do_strt = strt_chk_en;
  assign w_do_par  = par_chk_en & ~strt_chk_en;
  assign w_do_stp  = stp_chk_en & ~strt_chk_en & ~par_chk_en;

  logic w_glitch;
  logic w_par_bad;
  logic w_stp_bad;
  assign w_glitch  = w_do_strt & sambled_bit;
  assign w_par_bad = w_do_par & (sambled_bit ^ (^data_in) ^ par_typ);
  assign w_stp_bad = w_do_stp & ~sambled_bit;

  // A frame ends on the last stop strobe; stp_two is only consulted in STP1.
  logic w_frame_end;
  assign w_frame_end = w_do_stp &
                       (((r_state == STP1) & ~stp_two) | (r_state == STP2));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_frame_err   <= 1'b0;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_ok    <= 1'b0;
    end else begin
      r_strt_glitch <= w_glitch;
      r_par_err     <= w_par_bad;
      r_stp_err     <= w_stp_bad;
      r_frame_done  <= 1'b0;
      r_frame_ok    <= 1'b0;
      if (w_do_strt) begin
        r_state     <= STP1;
        r_frame_err <= sambled_bit;
      end else if (w_do_par) begin
        r_frame_err <= r_frame_err | w_par_bad;
      end else if (w_frame_end) begin
        r_state      <= IDLE;
        r_frame_err  <= 1'b0;
        r_frame_done <= 1'b1;
        r_frame_ok   <= ~(r_frame_err | w_stp_bad);
      end else if (w_do_stp && r_state == STP1) begin
        r_state     <= STP2;
        r_frame_err <= r_frame_err | w_stp_bad;
      end
    end
  end

  assign strt_glitch = r_strt_glitch;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;
  assign frame_done  = r_frame_done;
  assign frame_ok    = r_frame_ok;

  // Counter index 0 = glitch, 1 = parity, 2 = stop.
  logic [2:0]             w_inc;
  logic [3*CNT_WIDTH-1:0] w_cnt_bus;
  assign w_inc = {w_stp_bad, w_par_bad, w_glitch};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] r_cnt;
      always_ff @(posedge CLK) begin
        if (RST || cnt_clr) begin
          r_cnt <= '0;
        end else if (w_inc[gi] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
      assign w_cnt_bus[gi*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end
  endgenerate

  assign glitch_cnt  = w_cnt_bus[0*CNT_WIDTH +: CNT_WIDTH];
  assign par_err_cnt = w_cnt_bus[1*CNT_WIDTH +: CNT_WIDTH];
  assign stp_err_cnt = w_cnt_bus[2*CNT_WIDTH +: CNT_WIDTH];

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Self-checking bench for uart_rx_frame_chk: directed frame scenarios followed by
// randomized strobes, all compared each cycle against a frame-level reference model.
module tb_uart_rx_frame_chk;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST, sambled_bit, strt_chk_en, par_chk_en, stp_chk_en;
  logic [DW-1:0] data_in;
  logic          par_typ, stp_two, cnt_clr;
  logic          strt_glitch, par_err, stp_err, frame_done, frame_ok;
  logic [CW-1:0] glitch_cnt, par_err_cnt, stp_err_cnt;

  uart_rx_frame_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .sambled_bit(sambled_bit),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .data_in(data_in), .par_typ(par_typ), .stp_two(stp_two), .cnt_clr(cnt_clr),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .frame_done(frame_done), .frame_ok(frame_ok),
    .glitch_cnt(glitch_cnt), .par_err_cnt(par_err_cnt), .stp_err_cnt(stp_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int n_frames = 0;

  // Reference model: frame membership, stop bits still owed, and whether the frame went bad.
  bit m_in_frame = 0;
  int m_stops_left = -1;
  bit m_bad = 0;
  bit e_glitch, e_par, e_stp, e_done, e_ok;
  int e_cnt [3];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit p, input bit t, input bit b,
                      input logic [DW-1:0] d, input bit ty, input bit two,
                      input bit clr, input bit rst);
    bit fl [3];
    strt_chk_en = s; par_chk_en = p; stp_chk_en = t; sambled_bit = b;
    data_in = d; par_typ = ty; stp_two = two; cnt_clr = clr; RST = rst;
    if (rst) begin
      e_glitch = 0; e_par = 0; e_stp = 0; e_done = 0; e_ok = 0;
      m_in_frame = 0; m_stops_left = -1; m_bad = 0;
      for (int k = 0; k < 3; k++) e_cnt[k] = 0;
    end else begin
      e_glitch = s & b;
      e_par    = !s && p && (b ^ (^d) ^ ty);
      e_stp    = !s && !p && t && !b;
      e_done   = 0;
      e_ok     = 0;
      if (s) begin
        m_in_frame = 1; m_stops_left = -1; m_bad = b;
      end else if (p) begin
        if (m_in_frame) m_bad = m_bad | e_par;
      end else if (t && m_in_frame) begin
        m_bad = m_bad | e_stp;
        if (m_stops_left < 0) m_stops_left = two ? 2 : 1;
        m_stops_left--;
        if (m_stops_left == 0) begin
          e_done = 1; e_ok = !m_bad; m_in_frame = 0;
        end
      end
      fl[0] = e_glitch; fl[1] = e_par; fl[2] = e_stp;
      for (int k = 0; k < 3; k++) begin
        if (clr) e_cnt[k] = 0;
        else if (fl[k] && e_cnt[k] < CMAX) e_cnt[k]++;
      end
    end
    @(posedge CLK);
    #1;
    check_val("strt_glitch", 32'(strt_glitch), 32'(e_glitch));
    check_val("par_err",     32'(par_err),     32'(e_par));
    check_val("stp_err",     32'(stp_err),     32'(e_stp));
    check_val("frame_done",  32'(frame_done),  32'(e_done));
    check_val("frame_ok",    32'(frame_ok),    32'(e_ok));
    check_val("glitch_cnt",  32'(glitch_cnt),  32'(e_cnt[0]));
    check_val("par_err_cnt", 32'(par_err_cnt), 32'(e_cnt[1]));
    check_val("stp_err_cnt", 32'(stp_err_cnt), 32'(e_cnt[2]));
  endtask

  task automatic idle();                  step(0,0,0,0,'0,0,0,0,0); endtask
  task automatic do_strt(input bit b);    step(1,0,0,b,'0,0,0,0,0); endtask
  task automatic do_par(input bit b, input logic [DW-1:0] d, input bit ty);
    step(0,1,0,b,d,ty,0,0,0);
  endtask
  task automatic do_stp(input bit b, input bit two); step(0,0,1,b,'0,0,two,0,0); endtask
  task automatic do_rst();                step(0,0,0,0,'0,0,0,0,1); endtask

  initial begin
    do_rst(); do_rst();
    check_val("rst_state_cnt", 32'(stp_err_cnt), 32'd0);
    $display("txn reset");

    // Clean 0xA5 frame, even parity, one stop bit.
    do_strt(0); idle(); idle(); do_par(0, 8'hA5, 0); do_stp(1, 0);
    check_val("clean_done", 32'(frame_done), 32'd1);
    check_val("clean_ok",   32'(frame_ok),   32'd1);
    check_val("clean_pcnt", 32'(par_err_cnt), 32'd0);
    $display("txn clean_frame done=%0d ok=%0d", frame_done, frame_ok);

    // Start glitch spoils an otherwise clean frame.
    do_strt(1);
    check_val("glitch_flag", 32'(strt_glitch), 32'd1);
    check_val("glitch_cnt1", 32'(glitch_cnt),  32'd1);
    idle();
    check_val("glitch_one_cycle", 32'(strt_glitch), 32'd0);
    do_par(0, 8'hA5, 0); do_stp(1, 0);
    check_val("glitch_frame_ok", 32'(frame_ok), 32'd0);
    $display("txn start_glitch ok=%0d", frame_ok);

    // Odd parity on 0x07.
    do_strt(0); do_par(1, 8'h07, 1);
    check_val("odd_par_err", 32'(par_err), 32'd1);
    check_val("odd_par_cnt", 32'(par_err_cnt), 32'd1);
    do_stp(1, 0);
    do_strt(0); do_par(0, 8'h07, 1);
    check_val("odd_par_ok", 32'(par_err), 32'd0);
    do_stp(1, 0);
    check_val("odd_par_frame_ok", 32'(frame_ok), 32'd1);
    $display("txn odd_parity");

    // Two stop bits, second bad; stp_two dropping after STP1 is ignored.
    do_strt(0); do_par(0, 8'hA5, 0); do_stp(1, 1);
    check_val("two_stop_nodone", 32'(frame_done), 32'd0);
    do_stp(0, 0);
    check_val("two_stop_err",  32'(stp_err),    32'd1);
    check_val("two_stop_done", 32'(frame_done), 32'd1);
    check_val("two_stop_ok",   32'(frame_ok),   32'd0);
    $display("txn two_stop");

    // Start in STP2 aborts the frame.
    do_strt(0); do_par(0, 8'hA5, 0); do_stp(1, 1); do_strt(0);
    check_val("abort_nodone", 32'(frame_done), 32'd0);
    do_par(0, 8'hA5, 0); do_stp(1, 0);
    check_val("abort_restart_ok", 32'(frame_ok), 32'd1);
    $display("txn abort_in_stp2");

    // Stop-error counter saturation and clear priority (also stops seen in IDLE).
    step(0,0,0,0,'0,0,0,1,0);
    for (int k = 0; k < 5; k++) do_stp(0, 0);
    check_val("sat_cnt", 32'(stp_err_cnt), 32'd3);
    step(0,0,1,0,'0,0,0,1,0);
    check_val("clr_prio_flag", 32'(stp_err),     32'd1);
    check_val("clr_prio_cnt",  32'(stp_err_cnt), 32'd0);
    $display("txn saturate_and_clear");

    // Start and stop together, then reset inside STP2.
    step(1,0,1,0,'0,0,0,0,0);
    check_val("collide_stp_err", 32'(stp_err), 32'd0);
    do_stp(1, 1); do_rst();
    check_val("rst_mid_done", 32'(frame_done), 32'd0);
    idle(); do_stp(1, 0);
    check_val("rst_idle_nodone", 32'(frame_done), 32'd0);
    $display("txn collide_then_reset");

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      bit s, p, t, b, ty, two, clr, rst;
      logic [DW-1:0] d;
      int r;
      r   = int'($urandom_range(0, 99));
      s   = (r < 10);
      p   = (r >= 8 && r < 25) || ($urandom_range(0, 19) == 0);
      t   = (r >= 22 && r < 45) || ($urandom_range(0, 19) == 0);
      d   = DW'($urandom);
      ty  = 1'($urandom);
      two = 1'($urandom);
      clr = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if (s)      b = 0;
      else if (p) b = (^d) ^ ty;
      else        b = 1;
      if ($urandom_range(0, 3) == 0) b = !b;
      step(s, p, t, b, d, ty, two, clr, rst);
      if (e_done) begin
        n_frames++;
        $display("txn rand_frame cycle=%0d done=%0d ok=%0d exp_ok=%0d", c, frame_done, frame_ok, e_ok);
      end
    end
    $display("random frames completed: %0d", n_frames);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
